// File: rtl/mux_sel_sequencer_pkg.sv
// rtl/mux_sel_sequencer_pkg.sv - shared types and index helpers for the mux select sequencer
package mux_sel_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic int sel_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    function automatic int first_idx(input int width, input bit msb_first);
        return msb_first ? width - 1 : 0;
    endfunction

    function automatic int last_idx(input int width, input bit msb_first);
        return msb_first ? 0 : width - 1;
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// rtl/mux_sel_sequencer_if.sv - load handshake, step tick and mux-side signals of the sequencer
interface mux_sel_sequencer_if #(
    parameter int WIDTH = 8
);
    localparam int SEL_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             step_en;
    logic [WIDTH-1:0] mux_in;
    logic [SEL_W-1:0] mux_sel;
    logic             bit_valid;
    logic             frame_done;
    logic             busy;

    modport master (
        output load_valid, load_data, step_en,
        input  load_ready, mux_in, mux_sel, bit_valid, frame_done, busy
    );

    modport slave (
        input  load_valid, load_data, step_en,
        output load_ready, mux_in, mux_sel, bit_valid, frame_done, busy
    );

endinterface

// File: rtl/mux_sel_sequencer_sel_counter.sv
// rtl/mux_sel_sequencer_sel_counter.sv - loadable up/down select counter with last-index flag
module sel_counter #(
    parameter int               SEL_W    = 3,
    parameter logic [SEL_W-1:0] LAST_IDX = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [SEL_W-1:0] count,
    output logic             at_last
);
    localparam logic [SEL_W-1:0] ONE = SEL_W'(1);

    // Load wins over enable so a frame end or restart never double-moves the select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= dir ? (count - ONE) : (count + ONE);
        end
    end

    assign at_last = (count == LAST_IDX);

endmodule

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - holds a parallel word and steps the mux select across it, one bit per tick
module mux_sel_sequencer
    import mux_sel_sequencer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_sel_sequencer_if.slave  bus
);
    localparam int               SEL_W = sel_width(WIDTH);
    localparam logic [SEL_W-1:0] FIRST = SEL_W'(first_idx(WIDTH, MSB_FIRST));
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(last_idx(WIDTH, MSB_FIRST));

    state_t           state, state_nx;
    logic [WIDTH-1:0] data_q;
    logic             done_q;
    logic [SEL_W-1:0] sel;
    logic             at_last;
    logic             ready;
    logic             accept;
    logic             last_step;
    logic             cnt_load;
    logic             cnt_en;
    logic [SEL_W-1:0] cnt_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= last_step;
            if (accept) begin
                data_q <= bus.load_data;
            end
        end
    end

    // A word offered on the final step is taken immediately so frames run back to back
    always_comb begin
        last_step = (state == SCAN) & bus.step_en & at_last;
        ready     = (state == IDLE) | last_step;
        accept    = bus.load_valid & ready;
        state_nx  = state;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_en    = (state == SCAN) & bus.step_en;
        if (accept) begin
            state_nx = SCAN;
            cnt_load = 1'b1;
            cnt_val  = FIRST;
        end else if (last_step) begin
            state_nx = IDLE;
            cnt_load = 1'b1;
        end
    end

    sel_counter #(
        .SEL_W    (SEL_W),
        .LAST_IDX (LAST)
    ) u_sel_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .dir      (MSB_FIRST),
        .count    (sel),
        .at_last  (at_last)
    );

    assign bus.load_ready = ready;
    assign bus.mux_in     = data_q;
    assign bus.mux_sel    = sel;
    assign bus.bit_valid  = (state == SCAN);
    assign bus.busy       = (state == SCAN);
    assign bus.frame_done = done_q;

endmodule
